// File: rtl/alu4_pkg.sv
// Shared definitions for the alu4 status path: opcode class, condition codes, flag bundle.
package alu4_pkg;

    localparam int unsigned FLAG_W   = 4;
    localparam int unsigned RESULT_W = 4;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned COND_W   = 4;

    // op[2:1] value that marks add/sub; everything else is a logic op
    localparam logic [1:0] ARITH_OPS = 2'b11;

    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic c;
        logic n;
        logic z;
        logic v;
    } flags_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_e;

    function automatic logic is_arith(input logic [OP_W-1:0] op);
        return (op[2:1] == ARITH_OPS);
    endfunction

endpackage

// File: rtl/flag_reg4_cond_eval4.sv
// Condition-code evaluator: maps a 4-bit condition selector onto a set of NZCV flags.
module cond_eval4
    import alu4_pkg::*;
(
    input  flags_t              flags,
    input  logic [COND_W-1:0]   cond,
    output logic                cond_true
);

    logic n_eq_v;

    assign n_eq_v = (flags.n == flags.v);

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_true = flags.z;
            COND_NE: cond_true = !flags.z;
            COND_CS: cond_true = flags.c;
            COND_CC: cond_true = !flags.c;
            COND_MI: cond_true = flags.n;
            COND_PL: cond_true = !flags.n;
            COND_VS: cond_true = flags.v;
            COND_VC: cond_true = !flags.v;
            COND_HI: cond_true = flags.c & !flags.z;
            COND_LS: cond_true = !flags.c | flags.z;
            COND_GE: cond_true = n_eq_v;
            COND_LT: cond_true = !n_eq_v;
            COND_GT: cond_true = !flags.z & n_eq_v;
            COND_LE: cond_true = flags.z | !n_eq_v;
            COND_AL: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_reg4.sv
// Registered ALU status stage: one-entry valid/ready buffer holding result and NZCV,
// with sticky carry/overflow, a saturating overflow counter and condition evaluation.
module flag_reg4
    import alu4_pkg::*;
#(
    parameter bit          KEEP_CV = 1'b1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     op,
    input  logic [RESULT_W-1:0] result,
    input  logic                c,
    input  logic                n,
    input  logic                z,
    input  logic                v,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] q_result,
    output logic                q_c,
    output logic                q_n,
    output logic                q_z,
    output logic                q_v,
    input  logic [COND_W-1:0]   cond,
    output logic                cond_true,
    input  logic                clr_sticky,
    output logic                sticky_c,
    output logic                sticky_v,
    output logic [CNT_W-1:0]    ovf_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    buf_state_e          state_q;
    buf_state_e          state_d;
    logic                accept;
    logic                arith;
    logic                load_cv;
    logic                sticky_c_d;
    logic                sticky_v_d;
    logic [CNT_W-1:0]    ovf_cnt_d;
    flags_t              held_flags;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign arith     = is_arith(op);
    assign load_cv   = arith | !KEEP_CV;

    // Buffer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a full buffer refills in the same cycle it drains
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_valid) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !in_valid) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Held entry; C/V only follow the input for arith ops unless KEEP_CV is off
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_result <= '0;
            q_n      <= 1'b0;
            q_z      <= 1'b0;
            q_c      <= 1'b0;
            q_v      <= 1'b0;
        end else if (accept) begin
            q_result <= result;
            q_n      <= n;
            q_z      <= z;
            if (load_cv) begin
                q_c <= c;
                q_v <= v;
            end
        end
    end

    // Clear first, then apply any event from the op accepted this cycle
    always_comb begin
        sticky_c_d = clr_sticky ? 1'b0 : sticky_c;
        sticky_v_d = clr_sticky ? 1'b0 : sticky_v;
        ovf_cnt_d  = clr_sticky ? '0 : ovf_cnt;
        if (accept && arith) begin
            if (c) begin
                sticky_c_d = 1'b1;
            end
            if (v) begin
                sticky_v_d = 1'b1;
                if (ovf_cnt_d != CNT_MAX) begin
                    ovf_cnt_d = ovf_cnt_d + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_c <= 1'b0;
            sticky_v <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            sticky_c <= sticky_c_d;
            sticky_v <= sticky_v_d;
            ovf_cnt  <= ovf_cnt_d;
        end
    end

    assign held_flags = '{c: q_c, n: q_n, z: q_z, v: q_v};

    cond_eval4 u_cond_eval4 (
        .flags     (held_flags),
        .cond      (cond),
        .cond_true (cond_true)
    );

endmodule
